// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: player-input front end for the arcade cores.
// Merges PS/2 key events and HPS joystick words into registered per-player
// direction, button, start and coin signals, with rotation remap, SOCD
// cleaning and coin pulse shaping.
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   synchronous, active-high
//   ps2_key    in   [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   joy_in     in   16 bits per player: [0]R [1]L [2]D [3]U [4+b] button b,
//                   [4+BUTTONS] start, [5+BUTTONS] coin
//   rotate     in   1 = apply rotation remap to directions
//   autofire   in   autofire enable (only with ARCADE_INPUT_AUTOFIRE_EN)
//   dir_out    out  per player {up,down,left,right} at [4p+:4]
//   btn_out    out  per player buttons at [BUTTONS*p+:BUTTONS]
//   start_out  out  start 1P/2P, level
//   coin_out   out  coin slot 1/2, COIN_PULSE-cycle pulse per request edge
//
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (btn0 autofire per player).
module arcade_input_ctrl #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 1,
  parameter int unsigned COIN_PULSE   = 240000,
  parameter int unsigned SOCD_NEUTRAL = 1,
  parameter int unsigned ROT_DIR      = 0,
  parameter int unsigned AF_HALF      = 200000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy_in,
  input  logic                         rotate,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic                         autofire,
`endif
  output logic [4*PLAYERS-1:0]         dir_out,
  output logic [BUTTONS*PLAYERS-1:0]   btn_out,
  output logic [1:0]                   start_out,
  output logic [1:0]                   coin_out
);

  localparam int unsigned DW    = 4 * PLAYERS;
  localparam int unsigned BW    = BUTTONS * PLAYERS;
  localparam int unsigned CNT_W = ($clog2(COIN_PULSE) > 0) ? $clog2(COIN_PULSE) : 1;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_PULSE, SLOT_HOLD} slot_e;

  logic          toggle_q, toggle_d;
  logic [DW-1:0] key_dir_q, key_dir_d;
  logic [BW-1:0] key_btn_q, key_btn_d;
  logic [1:0]    key_start_q, key_start_d;
  logic [1:0]    key_coin_q, key_coin_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [BW-1:0] btn_q, btn_d;
  logic [1:0]    start_q, start_d;
  logic [1:0]    coin_q, coin_d;
  logic [1:0]    req_prev_q;
  slot_e         state_q [2];
  slot_e         state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic          hit_dir_c, hit_btn_c, hit_start_c, hit_coin_c;
  logic          hit_p_c;
  logic [1:0]    hit_i_c;
  logic [BW-1:0] btn_merged_c;
  logic [1:0]    coin_req_c;
  logic [3:0]    raw_c, rot_c;
  logic          unused_joy;

  // Not every joystick word bit is mapped for every BUTTONS setting.
  assign unused_joy = ^joy_in;

  // Scancode decode; player-1 directions/buttons accept either extended state.
  always_comb begin
    hit_dir_c   = 1'b0;
    hit_btn_c   = 1'b0;
    hit_start_c = 1'b0;
    hit_coin_c  = 1'b0;
    hit_p_c     = 1'b0;
    hit_i_c     = 2'd0;
    case (ps2_key[7:0])
      8'h75: begin hit_dir_c = 1'b1; hit_i_c = 2'd3; end
      8'h72: begin hit_dir_c = 1'b1; hit_i_c = 2'd2; end
      8'h6B: begin hit_dir_c = 1'b1; hit_i_c = 2'd1; end
      8'h74: begin hit_dir_c = 1'b1; hit_i_c = 2'd0; end
      8'h14: begin hit_btn_c = 1'b1; hit_i_c = 2'd0; end
      8'h11: begin hit_btn_c = 1'b1; hit_i_c = 2'd1; end
      8'h29: begin hit_btn_c = 1'b1; hit_i_c = 2'd2; end
      8'h12: begin hit_btn_c = 1'b1; hit_i_c = 2'd3; end
      default: ;
    endcase
    if (!ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h2D: begin hit_dir_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd3; end
        8'h2B: begin hit_dir_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd2; end
        8'h23: begin hit_dir_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd1; end
        8'h34: begin hit_dir_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd0; end
        8'h1C: begin hit_btn_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd0; end
        8'h1B: begin hit_btn_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd1; end
        8'h15: begin hit_btn_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd2; end
        8'h1D: begin hit_btn_c = 1'b1; hit_p_c = 1'b1; hit_i_c = 2'd3; end
        8'h16, 8'h05: begin hit_start_c = 1'b1; hit_i_c = 2'd0; end
        8'h1E, 8'h06: begin hit_start_c = 1'b1; hit_i_c = 2'd1; end
        8'h2E: begin hit_coin_c = 1'b1; hit_i_c = 2'd0; end
        8'h36: begin hit_coin_c = 1'b1; hit_i_c = 2'd1; end
        default: ;
      endcase
    end
  end

  // Key registers update only on a toggle change; out-of-range players/buttons drop out.
  always_comb begin
    toggle_d    = ps2_key[10];
    key_dir_d   = key_dir_q;
    key_btn_d   = key_btn_q;
    key_start_d = key_start_q;
    key_coin_d  = key_coin_q;
    if (ps2_key[10] != toggle_q) begin
      for (int p = 0; p < PLAYERS; p++) begin
        for (int i = 0; i < 4; i++) begin
          if (hit_dir_c && hit_p_c == 1'(p) && hit_i_c == 2'(i)) key_dir_d[4*p+i] = ps2_key[9];
        end
        for (int b = 0; b < BUTTONS; b++) begin
          if (hit_btn_c && hit_p_c == 1'(p) && hit_i_c == 2'(b)) key_btn_d[BUTTONS*p+b] = ps2_key[9];
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (hit_start_c && hit_i_c == 2'(s)) key_start_d[s] = ps2_key[9];
        if (hit_coin_c && hit_i_c == 2'(s))  key_coin_d[s]  = ps2_key[9];
      end
    end
  end

  // Merge key|joy, then rotate, then SOCD clean.
  always_comb begin
    dir_d        = '0;
    btn_merged_c = key_btn_q;
    start_d      = key_start_q;
    coin_req_c   = key_coin_q;
    raw_c        = 4'd0;
    rot_c        = 4'd0;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_c = key_dir_q[4*p +: 4] | joy_in[16*p +: 4];
      rot_c = raw_c;
      if (rotate) begin
        if (ROT_DIR == 0) rot_c = {raw_c[1], raw_c[0], raw_c[2], raw_c[3]};
        else              rot_c = {raw_c[0], raw_c[1], raw_c[3], raw_c[2]};
      end
      if (SOCD_NEUTRAL != 0) begin
        if (rot_c[3] && rot_c[2]) rot_c[3:2] = 2'b00;
        if (rot_c[1] && rot_c[0]) rot_c[1:0] = 2'b00;
      end
      dir_d[4*p +: 4] = rot_c;
      btn_merged_c[BUTTONS*p +: BUTTONS] = key_btn_q[BUTTONS*p +: BUTTONS] | joy_in[16*p+4 +: BUTTONS];
      start_d[p]    = key_start_q[p] | joy_in[16*p + 4 + BUTTONS];
      coin_req_c[p] = key_coin_q[p]  | joy_in[16*p + 5 + BUTTONS];
    end
  end

  // Coin shaper next state: a request edge in IDLE starts a fixed-width pulse.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      case (state_q[s])
        SLOT_IDLE: begin
          if (coin_req_c[s] && !req_prev_q[s]) begin
            state_d[s] = SLOT_PULSE;
            cnt_d[s]   = CNT_W'(COIN_PULSE - 1);
          end
        end
        SLOT_PULSE: begin
          if (cnt_q[s] == '0) state_d[s] = coin_req_c[s] ? SLOT_HOLD : SLOT_IDLE;
          else                cnt_d[s]   = cnt_q[s] - CNT_W'(1);
        end
        SLOT_HOLD: begin
          if (!coin_req_c[s]) state_d[s] = SLOT_IDLE;
        end
        default: state_d[s] = SLOT_IDLE;
      endcase
    end
  end

  // Coin shaper output: registered alongside the slot state.
  always_comb begin
    for (int s = 0; s < 2; s++) coin_d[s] = (state_d[s] == SLOT_PULSE);
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AF_W = ($clog2(AF_HALF) > 0) ? $clog2(AF_HALF) : 1;

  logic [PLAYERS-1:0] af_act_q, af_act_d;
  logic [PLAYERS-1:0] af_phase_q, af_phase_d;
  logic [AF_W-1:0]    af_cnt_q [PLAYERS];
  logic [AF_W-1:0]    af_cnt_d [PLAYERS];

  // Autofire on btn0: starts high on press, inverts every AF_HALF cycles.
  always_comb begin
    btn_d      = btn_merged_c;
    af_act_d   = '0;
    af_phase_d = '0;
    for (int p = 0; p < PLAYERS; p++) af_cnt_d[p] = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (autofire && btn_merged_c[BUTTONS*p]) begin
        af_act_d[p] = 1'b1;
        if (!af_act_q[p]) begin
          af_cnt_d[p]   = '0;
          af_phase_d[p] = 1'b0;
        end else if (af_cnt_q[p] == AF_W'(AF_HALF - 1)) begin
          af_cnt_d[p]   = '0;
          af_phase_d[p] = ~af_phase_q[p];
        end else begin
          af_cnt_d[p]   = af_cnt_q[p] + AF_W'(1);
          af_phase_d[p] = af_phase_q[p];
        end
        btn_d[BUTTONS*p] = ~af_phase_d[p];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_act_q   <= '0;
      af_phase_q <= '0;
      for (int p = 0; p < PLAYERS; p++) af_cnt_q[p] <= '0;
    end else begin
      af_act_q   <= af_act_d;
      af_phase_q <= af_phase_d;
      for (int p = 0; p < PLAYERS; p++) af_cnt_q[p] <= af_cnt_d[p];
    end
  end
`else
  logic unused_af;
  assign unused_af = (AF_HALF == 0);

  always_comb btn_d = btn_merged_c;
`endif

  // State register; reset samples the toggle so it never fakes an event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q    <= ps2_key[10];
      key_dir_q   <= '0;
      key_btn_q   <= '0;
      key_start_q <= '0;
      key_coin_q  <= '0;
      dir_q       <= '0;
      btn_q       <= '0;
      start_q     <= '0;
      coin_q      <= '0;
      req_prev_q  <= '0;
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= SLOT_IDLE;
        cnt_q[s]   <= '0;
      end
    end else begin
      toggle_q    <= toggle_d;
      key_dir_q   <= key_dir_d;
      key_btn_q   <= key_btn_d;
      key_start_q <= key_start_d;
      key_coin_q  <= key_coin_d;
      dir_q       <= dir_d;
      btn_q       <= btn_d;
      start_q     <= start_d;
      coin_q      <= coin_d;
      req_prev_q  <= coin_req_c;
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
    end
  end

  assign dir_out   = dir_q;
  assign btn_out   = btn_q;
  assign start_out = start_q;
  assign coin_out  = coin_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl (PLAYERS=2, BUTTONS=2, COIN_PULSE=8).
module tb_arcade_input_ctrl;

  localparam int NP = 2;
  localparam int NB = 2;
  localparam int CP = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        rotate;
  logic [7:0]  dir_out;
  logic [3:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic        autofire = 1'b0;
`endif

  arcade_input_ctrl #(
    .PLAYERS(NP), .BUTTONS(NB), .COIN_PULSE(CP),
    .SOCD_NEUTRAL(1), .ROT_DIR(0), .AF_HALF(4)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .joy_in   (joy_in),
    .rotate   (rotate),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire (autofire),
`endif
    .dir_out  (dir_out),
    .btn_out  (btn_out),
    .start_out(start_out),
    .coin_out (coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] dir;
    logic [3:0] btn;
    logic [1:0] start;
    logic [1:0] coin;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pressed keys by meaning (dir order up,down,left,right).
  bit kdir [2][4];
  bit kbtn [2][4];
  bit kstart [2];
  bit kcoin [2];
  bit mtog;
  bit prev_req [2];
  int last_start [2];
  int cyc = 0;
  bit tog = 1'b1;
  logic [10:0] kw;

  int codes [22] = '{'h75, 'h72, 'h6B, 'h74, 'h14, 'h11, 'h29, 'h12, 'h2D, 'h2B, 'h23,
                     'h34, 'h1C, 'h1B, 'h15, 'h1D, 'h16, 'h05, 'h1E, 'h06, 'h2E, 'h36};

  // kind: 0 none, 1 direction, 2 button, 3 start, 4 coin
  function automatic void decode(input bit ext, input logic [7:0] code,
                                 output int kind, output int pl, output int idx);
    kind = 0; pl = 0; idx = 0;
    case (code)
      8'h75: begin kind = 1; idx = 0; end
      8'h72: begin kind = 1; idx = 1; end
      8'h6B: begin kind = 1; idx = 2; end
      8'h74: begin kind = 1; idx = 3; end
      8'h14: begin kind = 2; idx = 0; end
      8'h11: begin kind = 2; idx = 1; end
      8'h29: begin kind = 2; idx = 2; end
      8'h12: begin kind = 2; idx = 3; end
      default: ;
    endcase
    if (kind == 0 && !ext) begin
      case (code)
        8'h2D: begin kind = 1; pl = 1; idx = 0; end
        8'h2B: begin kind = 1; pl = 1; idx = 1; end
        8'h23: begin kind = 1; pl = 1; idx = 2; end
        8'h34: begin kind = 1; pl = 1; idx = 3; end
        8'h1C: begin kind = 2; pl = 1; idx = 0; end
        8'h1B: begin kind = 2; pl = 1; idx = 1; end
        8'h15: begin kind = 2; pl = 1; idx = 2; end
        8'h1D: begin kind = 2; pl = 1; idx = 3; end
        8'h16, 8'h05: begin kind = 3; idx = 0; end
        8'h1E, 8'h06: begin kind = 3; idx = 1; end
        8'h2E: begin kind = 4; idx = 0; end
        8'h36: begin kind = 4; idx = 1; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [10:0] kev(input bit pr, input bit ext, input logic [7:0] code);
    tog = ~tog;
    return {tog, pr, ext, code};
  endfunction

  // One clock of stimulus; the expected outputs after the coming edge are queued.
  task automatic step(input logic [10:0] k, input logic [31:0] j, input logic rot, input logic rst);
    exp_t e;
    bit req [2];
    bit u, d, l, r, nu, nd, nl, nr;
    int kind, pl, idx;
    @(negedge clk_sys);
    ps2_key = k; joy_in = j; rotate = rot; reset = rst;
    e = '0;
    if (rst) begin
      foreach (kdir[a, b]) kdir[a][b] = 1'b0;
      foreach (kbtn[a, b]) kbtn[a][b] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        kstart[s] = 1'b0; kcoin[s] = 1'b0; prev_req[s] = 1'b0; last_start[s] = -1000;
      end
      mtog = k[10];
    end else begin
      for (int p = 0; p < NP; p++) begin
        u = kdir[p][0] | j[16*p+3];
        d = kdir[p][1] | j[16*p+2];
        l = kdir[p][2] | j[16*p+1];
        r = kdir[p][3] | j[16*p+0];
        if (rot) begin
          nu = l; nd = r; nl = d; nr = u;
          u = nu; d = nd; l = nl; r = nr;
        end
        if (u && d) begin u = 0; d = 0; end
        if (l && r) begin l = 0; r = 0; end
        e.dir[4*p +: 4] = {u, d, l, r};
        for (int b = 0; b < NB; b++) e.btn[NB*p+b] = kbtn[p][b] | j[16*p+4+b];
        e.start[p] = kstart[p] | j[16*p+4+NB];
        req[p]     = kcoin[p]  | j[16*p+5+NB];
      end
      // A request edge starts a pulse only if the low before it came after the last pulse ended.
      for (int s = 0; s < 2; s++) begin
        if (req[s] && !prev_req[s] && (cyc - 1 >= last_start[s] + CP)) last_start[s] = cyc;
        e.coin[s] = (cyc - last_start[s]) < CP;
        prev_req[s] = req[s];
      end
      if (k[10] != mtog) begin
        decode(k[8], k[7:0], kind, pl, idx);
        case (kind)
          1: kdir[pl][idx] = k[9];
          2: kbtn[pl][idx] = k[9];
          3: kstart[idx]   = k[9];
          4: kcoin[idx]    = k[9];
          default: ;
        endcase
        mtog = k[10];
      end
    end
    sb.push_back(e);
    cyc++;
  endtask

  // Monitor: every edge the DUT presents a new registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp += 4;
        if (dir_out !== e.dir) begin
          n_bad++; $display("FAIL dir_out t=%0t got=%b exp=%b", $time, dir_out, e.dir);
        end
        if (btn_out !== e.btn) begin
          n_bad++; $display("FAIL btn_out t=%0t got=%b exp=%b", $time, btn_out, e.btn);
        end
        if (start_out !== e.start) begin
          n_bad++; $display("FAIL start_out t=%0t got=%b exp=%b", $time, start_out, e.start);
        end
        if (coin_out !== e.coin) begin
          n_bad++; $display("FAIL coin_out t=%0t got=%b exp=%b", $time, coin_out, e.coin);
        end
      end
    end
  end

  initial begin
    logic [31:0] j;
    logic        rot;
    logic [7:0]  code;
    reset = 1'b1; rotate = 1'b0; joy_in = '0;
    kw = {1'b1, 1'b1, 1'b0, 8'h75};
    ps2_key = kw;
    // Reset with toggle high and an up-key pattern held: no event afterwards.
    repeat (3) step(kw, '0, 1'b0, 1'b1);
    repeat (10) step(kw, '0, 1'b0, 1'b0);

    // P1 up, normal then extended.
    for (int x = 0; x < 2; x++) begin
      kw = kev(1'b1, 1'(x), 8'h75); repeat (4) step(kw, '0, 1'b0, 1'b0);
      kw = kev(1'b0, 1'(x), 8'h75); repeat (4) step(kw, '0, 1'b0, 1'b0);
    end
    // P2 key with extended set must be ignored.
    kw = kev(1'b1, 1'b1, 8'h2D); repeat (3) step(kw, '0, 1'b0, 1'b0);

    // SOCD and rotation.
    repeat (3) step(kw, 32'h0000_000C, 1'b0, 1'b0);
    repeat (3) step(kw, 32'h0000_0002, 1'b1, 1'b0);
    repeat (3) step(kw, 32'h0003_0000, 1'b0, 1'b0);

    // Coin key held 20 cycles, released, re-pressed.
    kw = kev(1'b1, 1'b0, 8'h2E); repeat (20) step(kw, '0, 1'b0, 1'b0);
    kw = kev(1'b0, 1'b0, 8'h2E); repeat (3)  step(kw, '0, 1'b0, 1'b0);
    kw = kev(1'b1, 1'b0, 8'h2E); repeat (12) step(kw, '0, 1'b0, 1'b0);
    kw = kev(1'b0, 1'b0, 8'h2E); repeat (3)  step(kw, '0, 1'b0, 1'b0);
    // Both slots together, P2 button1, then reset mid-pulse.
    repeat (12) step(kw, 32'h0080_0080, 1'b0, 1'b0);
    repeat (3)  step(kw, 32'h0020_0000, 1'b0, 1'b0);
    repeat (3)  step(kw, 32'h0080_0000, 1'b0, 1'b0);
    step(kw, 32'h0080_0000, 1'b0, 1'b1);
    repeat (4)  step(kw, 32'h0080_0000, 1'b0, 1'b0);
    repeat (2)  step(kw, '0, 1'b0, 1'b0);

    // Randomised traffic.
    rot = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0) code = 8'($urandom);
        else                           code = 8'(codes[$urandom_range(0, 21)]);
        kw = kev(1'($urandom), 1'($urandom_range(0, 3) == 0), code);
      end
      if ($urandom_range(0, 63) == 0) rot = ~rot;
      j = $urandom & $urandom & $urandom;
      step(kw, j, rot, 1'($urandom_range(0, 499) == 0));
    end
    repeat (3) step(kw, '0, 1'b0, 1'b0);

    repeat (3) @(posedge clk_sys);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Parametrised player-input front end for the arcade cores.
- Merges PS/2 keyboard events and HPS joystick words into registered per-player direction, button, start and coin signals.
- Adds rotation remap, SOCD cleaning and coin pulse shaping.
- Sits between hps_io and the game core; replaces ad-hoc per-core key decoding in emu.

Parameters:
- PLAYERS, 2: number of players, 1..2.
- BUTTONS, 1: fire buttons per player, 1..4.
- COIN_PULSE, 240000: coin output width in clk_sys cycles, ≥1.
- SOCD_NEUTRAL, 1: 1 = opposing directions cancel to neutral; 0 = pass both.
- ROT_DIR, 0: rotation sense when rotate=1. 0: up←left, down←right, left←down, right←up. 1: the inverse mapping.
- AF_HALF, 200000: autofire half-period in cycles (optional feature only).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joy_in  in  16*PLAYERS  joystick words, player p at [16p+:16]
- rotate  in  1  1 = apply rotation remap
- dir_out  out  4*PLAYERS  per player {up,down,left,right} at [4p+:4]
- btn_out  out  BUTTONS*PLAYERS  per player at [BUTTONS*p+:BUTTONS]
- start_out  out  2  start 1P/2P, level
- coin_out  out  2  coin slot 1/2, shaped pulse
- autofire  in  1  present only with ARCADE_INPUT_AUTOFIRE_EN

Behaviour:
- Event detect: register toggle_q holds the last sampled ps2_key[10]. When ps2_key[10]≠toggle_q, the matching key register takes ps2_key[9]; toggle_q then updates. Unmapped codes are ignored.
- Reset loads toggle_q from ps2_key[10], so reset never produces a spurious event.
- Key map, extended bit ignored:
  - P1 up/down/left/right: 75/72/6B/74
  - P1 btn0..3: 14 (Ctrl), 11 (Alt), 29 (Space), 12 (LShift)
- Key map, extended bit must be 0:
  - P2 up/down/left/right: 2D/2B/23/34
  - P2 btn0..3: 1C/1B/15/1D
  - start1: 16 or 05; start2: 1E or 06
  - coin1: 2E; coin2: 36
- Keys for players or buttons beyond the parameters are ignored.
- Joystick word layout:
  - [0] right, [1] left, [2] down, [3] up
  - [4+b] button b
  - [4+BUTTONS] start, [5+BUTTONS] coin
- Player p joystick start/coin drive start_out[p] and the coin request for slot p.
- Merge: raw = key | joy per signal, then rotation (when rotate=1), then SOCD.
  - SOCD_NEUTRAL=1: up&down → both 0; left&right → both 0.
- All outputs are registered.
  - Latency, key: toggle change at edge N → key reg at N+1 → output at N+2.
  - Latency, joystick: 1 cycle.
- Coin shaper, per slot:
  - Slot states: IDLE, PULSE, HOLD.
  - IDLE → PULSE on a rising edge of the coin request; coin_out=1 and counter=COIN_PULSE-1.
  - PULSE decrements the counter. At 0 it goes to HOLD if the request is still high, else IDLE. Further edges during PULSE are ignored.
  - HOLD → IDLE when the request goes low; coin_out=0.
  - Slots are independent; simultaneous requests pulse both.
- Reset values: all outputs 0, all key registers 0, counters 0, slots IDLE.
- Reset mid-pulse truncates the pulse on the next edge.

Optional Feature:
- Macro ARCADE_INPUT_AUTOFIRE_EN.
- Defined:
  - Adds the autofire port and a per-player counter.
  - While autofire=1 and merged btn0 is held, btn0 output starts at 1 on press and inverts every AF_HALF cycles.
  - Release, autofire=0 or reset clears the counter and sets the output to 0 (or to the raw level when autofire=0).
- Undefined: no port, no counters; btn0 passes through.

Test Plan:
- Reset with ps2_key[10]=1 held → no key registers set; all outputs 0 for 10 cycles.
- Toggle ps2_key to {1,1,0x075} at edge N → dir_out[3]=1 at N+2; toggle {0,1,0x075} → 0 two cycles later. Repeat with extended bit=1 → same result.
- joy_in[3:0]=4'b1100 (up+down), SOCD_NEUTRAL=1 → dir_out[3:2]=00; rotate=1, joy_in[1]=1 → P1 up asserted (ROT_DIR=0).
- COIN_PULSE=8: key 2E pressed for 20 cycles → coin_out[0] high exactly 8 cycles, no retrigger. Release then re-press → second 8-cycle pulse. Press coin1 and coin2 together → both pulse.
- PLAYERS=2, BUTTONS=2: joy_in[16+5]=1 → btn_out[3]=1; joy_in[16+7] (P2 coin) → coin_out[1] pulses.
- ARCADE_INPUT_AUTOFIRE_EN, AF_HALF=4, autofire=1, hold Ctrl 20 cycles → btn_out[0] pattern 1111 0000 1111 0000 1111. Assert reset mid-sequence → 0 next edge.
